// File: rtl/data_4x4_col_to_row_pkg.sv
// Shared layout constants and element indexing for the 4x4 transform path.
package data_4x4_col_to_row_pkg;

  localparam int unsigned ElemW = 8;
  localparam int unsigned Dim   = 4;
  localparam int unsigned ColW  = Dim * ElemW;
  localparam int unsigned MatW  = Dim * ColW;

  // Row-major element index; data_4x4_transform uses the same mapping.
  function automatic int unsigned idx(input int unsigned r, input int unsigned c);
    return r * Dim + c;
  endfunction

endpackage

// File: rtl/data_4x4_col_to_row_mat_bank.sv
// One row-major matrix register bank, written one column at a time.
module mat_bank
  import data_4x4_col_to_row_pkg::*;
#(
  parameter int unsigned W = ElemW,
  parameter int unsigned N = Dim
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             wr_en_i,
  input  logic [1:0]       col_idx_i,
  input  logic [N*W-1:0]   col_i,
  output logic [N*N*W-1:0] mat_o
);

  logic [N*N*W-1:0] mat_q, mat_d;

  always_comb begin
    mat_d = mat_q;
    if (clr_i) begin
      mat_d = '0;
    end else if (wr_en_i) begin
      for (int unsigned r = 0; r < N; r++) begin
        mat_d[idx(r, 32'(col_idx_i)) * W +: W] = col_i[r * W +: W];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mat_q <= '0;
    end else begin
      mat_q <= mat_d;
    end
  end

  assign mat_o = mat_q;

endmodule

// File: rtl/data_4x4_col_to_row.sv
// Column-beat to row-major matrix converter with a two-bank ping-pong buffer.
module data_4x4_col_to_row
  import data_4x4_col_to_row_pkg::*;
#(
  parameter int unsigned W = ElemW,
  parameter int unsigned N = Dim
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sof,
  input  logic [N*W-1:0]   in_col,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N*N*W-1:0] out_data,
  output logic             err_sof
);

  if (N != 4) begin : g_bad_n
    $error("data_4x4_col_to_row supports N == 4 only");
  end

  logic [1:0]       full_q, full_d;
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [1:0]       col_cnt_q, col_cnt_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic             in_fire, out_fire, drop, restart, wr_en;
  logic [1:0]       wr_col;
  logic [1:0]       bank_we, bank_clr;
  logic [N*N*W-1:0] bank_mat [2];

  assign in_ready  = !full_q[wr_bank_q];
  assign in_fire   = in_valid && in_ready;
  assign out_valid = full_q[rd_bank_q];
  assign out_fire  = out_valid && out_ready;
  assign out_data  = bank_mat[rd_bank_q];
  assign err_sof   = err_q;

  always_comb begin
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    col_cnt_d = col_cnt_q;
    busy_d    = busy_q;
    drop      = in_fire && !busy_q && !in_sof;
    restart   = in_fire && busy_q && in_sof;
    wr_en     = in_fire && !drop;
    // A start-of-matrix beat always lands in column 0, abandoning any partial matrix.
    wr_col    = in_sof ? 2'd0 : col_cnt_q;
    err_d     = drop || restart;
    if (wr_en) begin
      if (wr_col == 2'(N - 1)) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = !wr_bank_q;
        col_cnt_d         = 2'd0;
        busy_d            = 1'b0;
      end else begin
        col_cnt_d = wr_col + 2'd1;
        busy_d    = 1'b1;
      end
    end
    // The reader only pops a full bank, which the writer never targets.
    if (out_fire) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = !rd_bank_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      col_cnt_q <= '0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      col_cnt_q <= col_cnt_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    assign bank_we[b]  = wr_en && (wr_bank_q == 1'(b));
    assign bank_clr[b] = out_fire && (rd_bank_q == 1'(b));

    mat_bank #(
      .W(W),
      .N(N)
    ) u_bank (
      .clk_i    (clk),
      .rst_i    (rst),
      .clr_i    (bank_clr[b]),
      .wr_en_i  (bank_we[b]),
      .col_idx_i(wr_col),
      .col_i    (in_col),
      .mat_o    (bank_mat[b])
    );
  end

endmodule
